// File: rtl/fir_pkg.sv
// fir_pkg: sizing and saturation helpers shared by the fast FIR datapath
package fir_pkg;

    // Widest accumulator the saturation helper can carry
    localparam int MAX_W = 128;

    function automatic int sub_taps(input int n);
        return (n + 1) / 2;
    endfunction

    function automatic int acc_w(input int in_w, input int tap_w, input int n);
        return in_w + tap_w + 2 + $clog2(sub_taps(n)) + 1;
    endfunction

    // Clamp v into the signed range of a w-bit word
    function automatic logic signed [MAX_W-1:0] saturate(input logic signed [MAX_W-1:0] v, input int w);
        logic signed [MAX_W-1:0] hi;
        hi = (MAX_W'(1) << (w - 1)) - 1;
        return v > hi ? hi : v < ~hi ? ~hi : v;
    endfunction

endpackage

// File: rtl/fir_fast_l2_subfilter.sv
// fir_subfilter: enable-gated delay line feeding a registered full-length dot product
module fir_subfilter import fir_pkg::*; #(
    parameter int IN_W   = 16,
    parameter int COEF_W = 32,
    parameter int TAPS   = 26,
    parameter int ACC_W  = 56
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic signed [IN_W-1:0]  x,
    input  logic [TAPS*COEF_W-1:0]  coefs,
    output logic signed [ACC_W-1:0] p
);

    logic signed [IN_W-1:0]  line [TAPS];
    logic signed [ACC_W-1:0] dot;

    // Shift a sample in only on accepted pairs so bubbles leave the history untouched
    always_ff @(posedge clk) begin
        if (reset) begin
            line <= '{default: '0};
        end else if (en) begin
            line[0] <= x;
            for (int i = 1; i < TAPS; i++) line[i] <= line[i-1];
        end
    end

    // Exact sum of products across the whole line
    always_comb begin
        dot = '0;
        for (int i = 0; i < TAPS; i++)
            dot = dot + ACC_W'(line[i]) * ACC_W'($signed(coefs[i*COEF_W +: COEF_W]));
    end

    // Register the dot product every cycle; it only moves after the line moves
    always_ff @(posedge clk) p <= reset ? '0 : dot;

endmodule

// File: rtl/fir_fast_l2.sv
// fir_fast_l2: two-samples-per-clock fast FIR (L=2) built from three half-length subfilters
module fir_fast_l2 import fir_pkg::*; #(
    parameter int DATA_IN_WIDTH  = 16,
    parameter int DATA_OUT_WIDTH = 64,
    parameter int TAP_WIDTH      = 32,
    parameter int TAP_COUNT      = 51,
    // h(j) lives at COEFS[j*TAP_WIDTH +: TAP_WIDTH]; the default is a unit impulse
    parameter logic [TAP_COUNT*TAP_WIDTH-1:0] COEFS =
        {{((TAP_COUNT - 1) * TAP_WIDTH){1'b0}}, {(TAP_WIDTH - 1){1'b0}}, 1'b1}
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             in_valid,
    input  logic signed [DATA_IN_WIDTH-1:0]  data_in0,
    input  logic signed [DATA_IN_WIDTH-1:0]  data_in1,
    output logic                             out_valid,
    output logic signed [DATA_OUT_WIDTH-1:0] data_out0,
    output logic signed [DATA_OUT_WIDTH-1:0] data_out1
);

    localparam int SUB = sub_taps(TAP_COUNT);
    localparam int AW  = acc_w(DATA_IN_WIDTH, TAP_WIDTH, TAP_COUNT);

    logic [SUB*TAP_WIDTH-1:0]     c0, c1;
    logic [SUB*(TAP_WIDTH+1)-1:0] c01;
    logic signed [DATA_IN_WIDTH:0] x01;
    logic signed [AW-1:0] p0, p1, p01, p1_d, y0, y1;
    logic valid_a, valid_b;

    // Polyphase split: even taps to H0, odd taps to H1 (zero past the end), H01 = H0 + H1
    for (genvar i = 0; i < SUB; i++) begin : g_split
        localparam int ODD = 2 * i + 1;
        localparam logic [TAP_WIDTH-1:0] E = COEFS[2*i*TAP_WIDTH +: TAP_WIDTH];
        localparam logic [TAP_WIDTH-1:0] O =
            ODD < TAP_COUNT ? COEFS[(ODD < TAP_COUNT ? ODD : 0)*TAP_WIDTH +: TAP_WIDTH] : '0;
        assign c0[i*TAP_WIDTH +: TAP_WIDTH] = E;
        assign c1[i*TAP_WIDTH +: TAP_WIDTH] = O;
        assign c01[i*(TAP_WIDTH+1) +: TAP_WIDTH+1] = {E[TAP_WIDTH-1], E} + {O[TAP_WIDTH-1], O};
    end

    assign x01 = {data_in0[DATA_IN_WIDTH-1], data_in0} + {data_in1[DATA_IN_WIDTH-1], data_in1};

    fir_subfilter #(.IN_W(DATA_IN_WIDTH), .COEF_W(TAP_WIDTH), .TAPS(SUB), .ACC_W(AW)) u_h0 (
        .clk(clk), .reset(reset), .en(in_valid), .x(data_in0), .coefs(c0), .p(p0)
    );

    fir_subfilter #(.IN_W(DATA_IN_WIDTH), .COEF_W(TAP_WIDTH), .TAPS(SUB), .ACC_W(AW)) u_h1 (
        .clk(clk), .reset(reset), .en(in_valid), .x(data_in1), .coefs(c1), .p(p1)
    );

    fir_subfilter #(.IN_W(DATA_IN_WIDTH + 1), .COEF_W(TAP_WIDTH + 1), .TAPS(SUB), .ACC_W(AW)) u_h01 (
        .clk(clk), .reset(reset), .en(in_valid), .x(x01), .coefs(c01), .p(p01)
    );

    // Valid follows the pair through line, product and output stages
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_a   <= 1'b0;
            valid_b   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            valid_a   <= in_valid;
            valid_b   <= valid_a;
            out_valid <= valid_b;
        end
    end

    // Recombine products; p1_d steps per pair so the block delay ignores bubbles
    always_ff @(posedge clk) begin
        if (reset) begin
            p1_d <= '0;
            y0   <= '0;
            y1   <= '0;
        end else if (valid_b) begin
            p1_d <= p1;
            y0   <= p0 + p1_d;
            y1   <= p01 - p0 - p1;
        end
    end

    if (DATA_OUT_WIDTH >= AW) begin : g_ext
        assign data_out0 = DATA_OUT_WIDTH'(y0);
        assign data_out1 = DATA_OUT_WIDTH'(y1);
    end else begin : g_sat
        assign data_out0 = DATA_OUT_WIDTH'(saturate(MAX_W'(y0), DATA_OUT_WIDTH));
        assign data_out1 = DATA_OUT_WIDTH'(saturate(MAX_W'(y1), DATA_OUT_WIDTH));
    end

endmodule

// File: tb/tb_fir_fast_l2.sv
// tb_fir_fast_l2: four filter variants driven by one stream, checked against direct convolution
module tb_fir_fast_l2;

    localparam int W  = 32;
    localparam int NP = 40;
    localparam longint NONE = 64'h7fff_dead_beef_0000;

    typedef struct {
        logic signed [15:0] x0, x1;
        longint e0, e1;
    } row_t;

    function automatic logic [W-1:0] tap(input int n, input int j);
        int v;
        v = ((j + 7) * (n + 13) * 2654435) ^ (j * 32'sh5bd1e995);
        return v;
    endfunction

    function automatic logic [63*W-1:0] taps_of(input int n);
        logic [63*W-1:0] r;
        r = '0;
        for (int j = 0; j < n; j++) r[j*W +: W] = tap(n, j);
        return r;
    endfunction

    localparam logic [63*W-1:0] T51 = taps_of(51);
    localparam logic [63*W-1:0] T5  = taps_of(5);
    localparam logic [63*W-1:0] T6  = taps_of(6);

    logic clk = 0, reset = 1, in_valid = 0;
    logic signed [15:0] x0 = 0, x1 = 0;
    logic ov [4];
    logic signed [63:0] y0 [3], y1 [3];
    logic signed [19:0] s0, s1;
    longint q [4][$];
    longint xs [$];
    int passed = 0, total = 0;
    logic signed [15:0] sa [NP], sb [NP];
    row_t tbl [12];

    always #5 clk = ~clk;

    fir_fast_l2 #(.TAP_COUNT(51), .COEFS(T51[51*W-1:0])) u51 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .data_in0(x0), .data_in1(x1),
        .out_valid(ov[0]), .data_out0(y0[0]), .data_out1(y1[0])
    );
    fir_fast_l2 #(.TAP_COUNT(5), .COEFS(T5[5*W-1:0])) u5 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .data_in0(x0), .data_in1(x1),
        .out_valid(ov[1]), .data_out0(y0[1]), .data_out1(y1[1])
    );
    fir_fast_l2 #(.TAP_COUNT(6), .COEFS(T6[6*W-1:0])) u6 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .data_in0(x0), .data_in1(x1),
        .out_valid(ov[2]), .data_out0(y0[2]), .data_out1(y1[2])
    );
    fir_fast_l2 #(.DATA_OUT_WIDTH(20), .TAP_COUNT(5), .COEFS({5{32'h7fffffff}})) usat (
        .clk(clk), .reset(reset), .in_valid(in_valid), .data_in0(x0), .data_in1(x1),
        .out_valid(ov[3]), .data_out0(s0), .data_out1(s1)
    );

    // Collect every valid output pair as two consecutive samples y(2k), y(2k+1)
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++)
            if (ov[k]) begin
                q[k].push_back(y0[k]);
                q[k].push_back(y1[k]);
            end
        if (ov[3]) begin
            q[3].push_back(longint'(s0));
            q[3].push_back(longint'(s1));
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic longint model_y(input int k, input int n);
        longint s;
        int nt;
        s  = 0;
        nt = k == 0 ? 51 : k == 2 ? 6 : 5;
        for (int j = 0; j < nt; j++)
            if (n >= j) s += longint'($signed(k == 3 ? 32'h7fffffff : tap(nt, j))) * xs[n-j];
        if (k == 3) s = s > 524287 ? 524287 : s < -524288 ? -524288 : s;
        return s;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic send(input logic v, input logic signed [15:0] a, input logic signed [15:0] b);
        in_valid = v;
        x0 = a;
        x1 = b;
        if (v) begin
            xs.push_back(longint'(a));
            xs.push_back(longint'(b));
        end
        @(posedge clk);
        #1;
        in_valid = 0;
    endtask

    task automatic drain();
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic v);
        reset = 1;
        in_valid = v;
        x0 = 16'sd1234;
        x1 = -16'sd999;
        @(posedge clk);
        #1;
        reset = 0;
        in_valid = 0;
        @(negedge clk);
        for (int k = 0; k < 4; k++) chk($sformatf("reset_out_valid_k%0d", k), longint'(ov[k]), 0);
        chk("reset_data_out0", y0[0], 0);
        chk("reset_sat_data_out1", longint'(s1), 0);
        xs.delete();
        for (int k = 0; k < 4; k++) q[k].delete();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("%s_count_k%0d", tag, k), q[k].size(), xs.size());
            for (int n = 0; n < xs.size(); n++)
                chk($sformatf("%s_k%0d_y%0d", tag, k, n), n < q[k].size() ? q[k][n] : NONE, model_y(k, n));
        end
    endtask

    initial begin
        for (int r = 0; r < 12; r++)
            if (r < 6) tbl[r] = '{16'sh7fff, 16'sh7fff, 524287, 524287};
            else tbl[r] = '{16'sh8000, 16'sh8000, -524288, -524288};
        for (int i = 0; i < NP; i++) begin
            sa[i] = 16'($urandom);
            sb[i] = 16'($urandom);
        end
        @(posedge clk);
        #1;
        do_reset(0);

        send(1, 1, 0);
        @(negedge clk);
        chk("latency_cycle1_out_valid", longint'(ov[0]), 0);
        @(negedge clk);
        chk("latency_cycle2_out_valid", longint'(ov[0]), 0);
        @(negedge clk);
        chk("latency_cycle3_out_valid", longint'(ov[0]), 1);
        chk("impulse_first_y0", y0[0], longint'($signed(tap(51, 0))));
        chk("impulse_first_y1", y1[0], longint'($signed(tap(51, 1))));
        @(posedge clk);
        #1;
        repeat (25) send(1, 0, 0);
        drain();
        for (int n = 0; n < 52; n++)
            chk($sformatf("impulse_h%0d", n), n < q[0].size() ? q[0][n] : NONE,
                n < 51 ? longint'($signed(tap(51, n))) : 0);
        check_all("impulse");

        do_reset(0);
        for (int i = 0; i < NP; i++) send(1, sa[i], sb[i]);
        drain();
        check_all("dense");

        do_reset(0);
        for (int i = 0; i < NP; i++) begin
            repeat ($urandom_range(0, 3)) send(0, 16'($urandom), 16'($urandom));
            send(1, sa[i], sb[i]);
        end
        drain();
        check_all("bubbles");

        do_reset(0);
        for (int i = 0; i < 10; i++) send(1, 16'($urandom), 16'($urandom));
        do_reset(1);
        for (int i = 0; i < 30; i++) begin
            repeat ($urandom_range(0, 1)) send(0, 16'($urandom), 16'($urandom));
            send(1, 16'($urandom), 16'($urandom));
        end
        drain();
        check_all("after_reset");

        for (int ph = 0; ph < 2; ph++) begin
            do_reset(0);
            for (int r = 0; r < 6; r++) send(1, tbl[ph*6+r].x0, tbl[ph*6+r].x1);
            drain();
            for (int r = 0; r < 6; r++) begin
                chk($sformatf("sat_ph%0d_y0_%0d", ph, r), 2*r < q[3].size() ? q[3][2*r] : NONE, tbl[ph*6+r].e0);
                chk($sformatf("sat_ph%0d_y1_%0d", ph, r), 2*r+1 < q[3].size() ? q[3][2*r+1] : NONE, tbl[ph*6+r].e1);
            end
            check_all("sat");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
